// File: rtl/fpu_seq_unit.sv
// Sequential single-precision FPU responder: one op in flight, fixed per-op latency, 1-cycle valid pulse.
// Optional build macro FPU_FMUL_ROUND_EN: FMUL rounds to nearest-even instead of truncating.
module fpu_seq_unit #(
    parameter int unsigned FMUL_LAT   = 3,
    parameter int unsigned SIMPLE_LAT = 1
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        distinct,
    input  logic        AorF,
    input  logic [3:0]  ALUOp,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        AorF_out,
    output logic [31:0] result,
    output logic        valid,
    output logic        busy
);

    localparam logic [3:0] OP_FMOV = 4'd0;
    localparam logic [3:0] OP_FNEG = 4'd1;
    localparam logic [3:0] OP_FABS = 4'd2;
    localparam logic [3:0] OP_FMUL = 4'd3;
    localparam logic [3:0] OP_FEQ  = 4'd4;
    localparam logic [3:0] OP_FLT  = 4'd5;
    localparam logic [3:0] OP_FLE  = 4'd6;

    localparam logic [3:0] FMUL_LAT4   = 4'(FMUL_LAT);
    localparam logic [3:0] SIMPLE_LAT4 = 4'(SIMPLE_LAT);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  count_reg, count_next;
    logic [3:0]  op_reg, op_next;
    logic [31:0] a_reg, a_next, b_reg, b_next;
    logic [31:0] result_reg, result_next;
    logic        aorf_out_reg, aorf_out_next;

    // ---------------- FMUL datapath ----------------
    logic               sign_m;
    logic [7:0]         ea, eb;
    logic [47:0]        prod, p_norm;
    logic signed [9:0]  e_raw, e_norm, e_fin;
    logic [22:0]        mant_fin;
    logic [31:0]        fmul_res;
    logic               fmul_unused;

    assign sign_m = a_reg[31] ^ b_reg[31];
    assign ea     = a_reg[30:23];
    assign eb     = b_reg[30:23];
    assign prod   = {24'd0, 1'b1, a_reg[22:0]} * {24'd0, 1'b1, b_reg[22:0]};
    // Left-align so the leading one always sits at bit 47.
    assign p_norm = prod[47] ? prod : {prod[46:0], 1'b0};
    assign e_raw  = signed'({2'b00, ea}) + signed'({2'b00, eb}) - 10'sd127;
    assign e_norm = e_raw + signed'({9'd0, prod[47]});
    assign fmul_unused = ^p_norm;

`ifdef FPU_FMUL_ROUND_EN
    logic        guard_bit, sticky_bit, round_up;
    logic [23:0] mant_rnd;
    assign guard_bit  = p_norm[23];
    assign sticky_bit = |p_norm[22:0];
    assign round_up   = guard_bit & (sticky_bit | p_norm[24]);
    assign mant_rnd   = {1'b0, p_norm[46:24]} + {23'd0, round_up};
    // A carry out leaves the fraction all-zero, so only the exponent moves.
    assign mant_fin   = mant_rnd[22:0];
    assign e_fin      = e_norm + signed'({9'd0, mant_rnd[23]});
`else
    assign mant_fin   = p_norm[46:24];
    assign e_fin      = e_norm;
`endif

    always_comb begin
        fmul_res = {sign_m, 31'd0};
        if (ea == 8'd0 || eb == 8'd0)
            fmul_res = {sign_m, 31'd0};
        else if (ea == 8'hFF || eb == 8'hFF)
            fmul_res = {sign_m, 8'hFF, 23'd0};
        else if (e_fin >= 10'sd255)
            fmul_res = {sign_m, 8'hFF, 23'd0};
        else if (e_fin <= 10'sd0)
            fmul_res = {sign_m, 31'd0};
        else
            fmul_res = {sign_m, e_fin[7:0], mant_fin};
    end

    // ---------------- compares (sign-magnitude, +0 == -0) ----------------
    logic both_zero, cmp_eq, cmp_lt;
    assign both_zero = (a_reg[30:0] == 31'd0) && (b_reg[30:0] == 31'd0);
    assign cmp_eq    = (a_reg == b_reg) || both_zero;

    always_comb begin
        cmp_lt = 1'b0;
        if (both_zero)
            cmp_lt = 1'b0;
        else if (a_reg[31] != b_reg[31])
            cmp_lt = a_reg[31];
        else if (!a_reg[31])
            cmp_lt = a_reg[30:0] < b_reg[30:0];
        else
            cmp_lt = a_reg[30:0] > b_reg[30:0];
    end

    logic [31:0] calc_result;
    logic        calc_is_float;

    always_comb begin
        calc_result   = 32'd0;
        calc_is_float = 1'b1;
        case (op_reg)
            OP_FMOV: calc_result = a_reg;
            OP_FNEG: calc_result = a_reg ^ 32'h8000_0000;
            OP_FABS: calc_result = a_reg & 32'h7FFF_FFFF;
            OP_FMUL: calc_result = fmul_res;
            OP_FEQ: begin
                calc_result   = {31'd0, cmp_eq};
                calc_is_float = 1'b0;
            end
            OP_FLT: begin
                calc_result   = {31'd0, cmp_lt};
                calc_is_float = 1'b0;
            end
            OP_FLE: begin
                calc_result   = {31'd0, cmp_lt | cmp_eq};
                calc_is_float = 1'b0;
            end
            default: calc_result = 32'd0;
        endcase
    end

    // ---------------- control FSM ----------------
    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        op_next       = op_reg;
        a_next        = a_reg;
        b_next        = b_reg;
        result_next   = result_reg;
        aorf_out_next = aorf_out_reg;
        case (state_reg)
            S_IDLE: begin
                if (distinct && AorF) begin
                    op_next    = ALUOp;
                    a_next     = op1;
                    b_next     = op2;
                    count_next = (ALUOp == OP_FMUL) ? FMUL_LAT4 : SIMPLE_LAT4;
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (count_reg <= 4'd1) begin
                    result_next   = calc_result;
                    aorf_out_next = calc_is_float;
                    count_next    = 4'd0;
                    state_next    = S_DONE;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            count_reg    <= 4'd0;
            op_reg       <= 4'd0;
            a_reg        <= 32'd0;
            b_reg        <= 32'd0;
            result_reg   <= 32'd0;
            aorf_out_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            op_reg       <= op_next;
            a_reg        <= a_next;
            b_reg        <= b_next;
            result_reg   <= result_next;
            aorf_out_reg <= aorf_out_next;
        end
    end

    assign result   = result_reg;
    assign AorF_out = aorf_out_reg;
    assign valid    = (state_reg == S_DONE);
    assign busy     = (state_reg != S_IDLE);

endmodule

// File: tb/tb_fpu_seq_unit.sv
// Directed-vector bench for fpu_seq_unit: op table with hand-computed results plus latency/reset corner cases.
module tb_fpu_seq_unit;

    logic        CLK = 1'b0;
    logic        reset;
    logic        distinct;
    logic        AorF;
    logic [3:0]  ALUOp;
    logic [31:0] op1, op2;
    logic        AorF_out;
    logic [31:0] result;
    logic        valid;
    logic        busy;

    fpu_seq_unit #(.FMUL_LAT(3), .SIMPLE_LAT(1)) dut (
        .CLK      (CLK),
        .reset    (reset),
        .distinct (distinct),
        .AorF     (AorF),
        .ALUOp    (ALUOp),
        .op1      (op1),
        .op2      (op2),
        .AorF_out (AorF_out),
        .result   (result),
        .valid    (valid),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Entered at a negedge with the FSM idle; returns the number of edges from accept to valid.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        distinct = 1'b1;
        AorF     = 1'b1;
        ALUOp    = op;
        op1      = a;
        op2      = b;
        @(posedge CLK);
        @(negedge CLK);
        distinct = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (valid) begin
                lat = c;
                break;
            end
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        aorf;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    initial begin
        int lat;
        int exp_lat;
        int nvalid;
        logic [31:0] rnd_exp;

`ifdef FPU_FMUL_ROUND_EN
        rnd_exp = 32'h4010_0002;
`else
        rnd_exp = 32'h4010_0001;
`endif
        vecs[0]  = '{4'd3, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b1};
        vecs[1]  = '{4'd1, 32'h3F80_0000, 32'h0000_0000, 32'hBF80_0000, 1'b1};
        vecs[2]  = '{4'd2, 32'hBF80_0000, 32'h0000_0000, 32'h3F80_0000, 1'b1};
        vecs[3]  = '{4'd9, 32'h3F80_0000, 32'h4000_0000, 32'h0000_0000, 1'b1};
        vecs[4]  = '{4'd5, 32'hBF80_0000, 32'h3F00_0000, 32'h0000_0001, 1'b0};
        vecs[5]  = '{4'd4, 32'h0000_0000, 32'h8000_0000, 32'h0000_0001, 1'b0};
        vecs[6]  = '{4'd6, 32'h3F80_0000, 32'h3F00_0000, 32'h0000_0000, 1'b0};
        vecs[7]  = '{4'd3, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1};
        vecs[8]  = '{4'd3, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b1};
        vecs[9]  = '{4'd3, 32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 1'b1};
        vecs[10] = '{4'd3, 32'h3FC0_0001, 32'h3FC0_0001, rnd_exp,       1'b1};
        vecs[11] = '{4'd0, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b1};
        vecs[12] = '{4'd5, 32'h3F80_0000, 32'h3F00_0000, 32'h0000_0000, 1'b0};
        vecs[13] = '{4'd5, 32'hBF80_0000, 32'hBF00_0000, 32'h0000_0001, 1'b0};
        vecs[14] = '{4'd6, 32'h8000_0000, 32'h0000_0000, 32'h0000_0001, 1'b0};
        vecs[15] = '{4'd3, 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 1'b1};
        vecs[16] = '{4'd3, 32'h3F80_0000, 32'hBF80_0000, 32'hBF80_0000, 1'b1};
        vecs[17] = '{4'd6, 32'hBF00_0000, 32'hBF80_0000, 32'h0000_0000, 1'b0};

        reset    = 1'b1;
        distinct = 1'b0;
        AorF     = 1'b0;
        ALUOp    = 4'd0;
        op1      = 32'd0;
        op2      = 32'd0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        check("reset_result", result, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_aorf", {31'd0, AorF_out}, 32'd0);

        // Table-driven ops: result, destination flag, latency, single-cycle valid.
        for (int i = 0; i < NV; i++) begin
            exp_lat = (vecs[i].op == 4'd3) ? 3 : 1;
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            $display("vec %0d op=%0d a=%h b=%h -> result=%h aorf=%0b lat=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, result, AorF_out, lat);
            check($sformatf("vec%0d_latency", i), lat, exp_lat);
            check($sformatf("vec%0d_result", i), result, vecs[i].res);
            check($sformatf("vec%0d_aorf", i), {31'd0, AorF_out}, {31'd0, vecs[i].aorf});
            @(posedge CLK);
            @(negedge CLK);
            check($sformatf("vec%0d_valid_pulse", i), {31'd0, valid}, 32'd0);
        end

        // Request with AorF=0 must be ignored.
        distinct = 1'b1;
        AorF     = 1'b0;
        ALUOp    = 4'd1;
        op1      = 32'h3F80_0000;
        @(posedge CLK);
        @(negedge CLK);
        distinct = 1'b0;
        check("int_req_ignored_busy", {31'd0, busy}, 32'd0);
        $display("AorF=0 request: busy=%0b", busy);

        // FMUL with a second strobe while busy: exactly one valid, FMUL result.
        distinct = 1'b1;
        AorF     = 1'b1;
        ALUOp    = 4'd3;
        op1      = 32'h4000_0000;
        op2      = 32'h4040_0000;
        @(posedge CLK);
        @(negedge CLK);
        ALUOp  = 4'd1;
        op1    = 32'h3F80_0000;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        distinct = 1'b0;
        nvalid = 0;
        for (int c = 0; c < 10; c++) begin
            if (valid) begin
                nvalid++;
                check("busy_strobe_result", result, 32'h40C0_0000);
            end
            @(posedge CLK);
            @(negedge CLK);
        end
        check("busy_strobe_valid_count", nvalid, 1);
        $display("strobe during FMUL busy: valid pulses=%0d", nvalid);

        // Reset one cycle after accept: op dropped, outputs cleared, no valid.
        distinct = 1'b1;
        AorF     = 1'b1;
        ALUOp    = 4'd3;
        op1      = 32'h4000_0000;
        op2      = 32'h4040_0000;
        @(posedge CLK);
        @(negedge CLK);
        distinct = 1'b0;
        reset    = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        check("midop_reset_result", result, 32'd0);
        check("midop_reset_aorf", {31'd0, AorF_out}, 32'd0);
        check("midop_reset_busy", {31'd0, busy}, 32'd0);
        nvalid = 0;
        for (int c = 0; c < 8; c++) begin
            if (valid) nvalid++;
            @(posedge CLK);
            @(negedge CLK);
        end
        check("midop_reset_no_valid", nvalid, 0);
        $display("reset mid-FMUL: valid pulses=%0d result=%h", nvalid, result);

        // Unit still works after the aborted op.
        run_op(4'd1, 32'h3F80_0000, 32'd0, lat);
        check("post_reset_latency", lat, 1);
        check("post_reset_result", result, 32'hBF80_0000);
        $display("post-reset FNEG: result=%h lat=%0d", result, lat);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
